// File: rtl/ahb_lite_arbiter_pkg.sv
// Shared AHB-Lite encodings and the burst-length lookup used by the arbiter.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

package ahb_lite_defs;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_e;

  // Zero means unbounded (INCR): such a burst never blocks rearbitration.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      BURST_SINGLE:               len = 5'd1;
      BURST_INCR:                 len = 5'd0;
      BURST_WRAP4,  BURST_INCR4:  len = 5'd4;
      BURST_WRAP8,  BURST_INCR8:  len = 5'd8;
      BURST_WRAP16, BURST_INCR16: len = 5'd16;
      default:                    len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_lite_arbiter_burst_counter.sv
// Remaining-beat counter of the address-phase owner's burst; burst_done_o
// reflects the count after the current edge's update.
module ahb_lite_burst_counter
  import ahb_lite_defs::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ready_i,
  input  logic [1:0] htrans_i,
  input  logic [2:0] hburst_i,
  output logic       burst_done_o
);

  logic [4:0] rem_q;
  logic [4:0] rem_d;
  logic [4:0] len_s;

  assign len_s = burst_len(hburst_i);

  // Next remaining-beat count from the beat accepted on this edge
  always_comb begin
    rem_d = rem_q;
    if (ready_i) begin
      case (htrans_i)
        TRANS_NONSEQ: rem_d = (len_s == 5'd0) ? 5'd0 : len_s - 5'd1;
        TRANS_SEQ: begin
          if (rem_q != 5'd0) begin
            rem_d = rem_q - 5'd1;
          end else begin
            rem_d = rem_q;
          end
        end
        TRANS_IDLE:   rem_d = 5'd0;
        default:      rem_d = rem_q;
      endcase
    end else begin
      rem_d = rem_q;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= 5'd0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign burst_done_o = (rem_d == 5'd0);

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Two-master round-robin AHB-Lite arbiter with burst/lock protection and
// pipelined address/write-data muxing.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module ahb_lite_arbiter
  import ahb_lite_defs::*;
(
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HBUSREQ0,
  input  logic                  HBUSREQ1,
  input  logic                  HLOCK0,
  input  logic                  HLOCK1,
  output logic                  HGRANT0,
  output logic                  HGRANT1,
  input  logic [`BUS_WIDTH-1:0] HADDR0,
  input  logic [`BUS_WIDTH-1:0] HADDR1,
  input  logic [1:0]            HTRANS0,
  input  logic [1:0]            HTRANS1,
  input  logic                  HWRITE0,
  input  logic                  HWRITE1,
  input  logic [2:0]            HSIZE0,
  input  logic [2:0]            HSIZE1,
  input  logic [2:0]            HBURST0,
  input  logic [2:0]            HBURST1,
  input  logic [`BUS_WIDTH-1:0] HWDATA0,
  input  logic [`BUS_WIDTH-1:0] HWDATA1,
  input  logic                  HREADY,
  output logic [`BUS_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic                  HMASTLOCK,
  output logic [`BUS_WIDTH-1:0] HWDATA,
  output logic                  HMASTER
);

  logic       gnt_q, gnt_d;
  logic       aown_q, aown_d;
  logic       down_q, down_d;
  logic       burst_done_s;
  logic       rearb_ok_s;
  logic [1:0] busreq_s;
  logic [1:0] lock_s;

  assign busreq_s = {HBUSREQ1, HBUSREQ0};
  assign lock_s   = {HLOCK1, HLOCK0};

  assign HADDR     = aown_q ? HADDR1  : HADDR0;
  assign HTRANS    = aown_q ? HTRANS1 : HTRANS0;
  assign HWRITE    = aown_q ? HWRITE1 : HWRITE0;
  assign HSIZE     = aown_q ? HSIZE1  : HSIZE0;
  assign HBURST    = aown_q ? HBURST1 : HBURST0;
  assign HMASTLOCK = aown_q ? HLOCK1  : HLOCK0;
  assign HWDATA    = down_q ? HWDATA1 : HWDATA0;
  assign HMASTER   = aown_q;
  assign HGRANT0   = ~gnt_q;
  assign HGRANT1   = gnt_q;

  ahb_lite_burst_counter u_burst_counter (
    .clk_i        (HCLK),
    .rst_i        (HRESET),
    .ready_i      (HREADY),
    .htrans_i     (HTRANS),
    .hburst_i     (HBURST),
    .burst_done_o (burst_done_s)
  );

  // Owner pipeline advance and round-robin grant decision
  always_comb begin
    gnt_d      = gnt_q;
    aown_d     = aown_q;
    down_d     = down_q;
    rearb_ok_s = 1'b0;
    if (HREADY) begin
      down_d     = aown_q;
      aown_d     = gnt_q;
      rearb_ok_s = ~lock_s[gnt_q] & (burst_done_s | ~busreq_s[gnt_q]);
    end else begin
      rearb_ok_s = 1'b0;
    end
    if (rearb_ok_s) begin
      case (busreq_s)
        2'b11:   gnt_d = ~gnt_q;
        2'b01:   gnt_d = 1'b0;
        2'b10:   gnt_d = 1'b1;
        default: gnt_d = gnt_q;
      endcase
    end else begin
      gnt_d = gnt_q;
    end
  end

  // Grant and owner registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      gnt_q  <= 1'b0;
      aown_q <= 1'b0;
      down_q <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      aown_q <= aown_d;
      down_q <= down_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Scoreboard bench: a transfer-level model predicts every cycle's bus outputs,
// a monitor compares them against the arbiter.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module tb_ahb_lite_arbiter;

  logic                  HCLK;
  logic                  HRESET;
  logic                  HBUSREQ0, HBUSREQ1, HLOCK0, HLOCK1;
  logic                  HGRANT0, HGRANT1;
  logic [`BUS_WIDTH-1:0] HADDR0, HADDR1, HWDATA0, HWDATA1;
  logic [1:0]            HTRANS0, HTRANS1;
  logic                  HWRITE0, HWRITE1;
  logic [2:0]            HSIZE0, HSIZE1, HBURST0, HBURST1;
  logic                  HREADY;
  logic [`BUS_WIDTH-1:0] HADDR, HWDATA;
  logic [1:0]            HTRANS;
  logic                  HWRITE, HMASTLOCK, HMASTER;
  logic [2:0]            HSIZE, HBURST;

  ahb_lite_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1), .HLOCK0(HLOCK0), .HLOCK1(HLOCK1),
    .HGRANT0(HGRANT0), .HGRANT1(HGRANT1),
    .HADDR0(HADDR0), .HADDR1(HADDR1), .HTRANS0(HTRANS0), .HTRANS1(HTRANS1),
    .HWRITE0(HWRITE0), .HWRITE1(HWRITE1), .HSIZE0(HSIZE0), .HSIZE1(HSIZE1),
    .HBURST0(HBURST0), .HBURST1(HBURST1), .HWDATA0(HWDATA0), .HWDATA1(HWDATA1),
    .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HMASTER(HMASTER)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        mst;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic        mlock;
    logic [31:0] wdata;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Per-cycle stimulus for both masters
  logic        breq [2];
  logic        lck  [2];
  logic        wr   [2];
  logic [31:0] ad   [2];
  logic [31:0] wd   [2];
  logic [1:0]  tr   [2];
  logic [2:0]  sz   [2];
  logic [2:0]  bu   [2];
  logic        rdy;
  logic        rst;

  // Reference state: who holds the grant, the address phase, the data phase
  int m_gnt, m_aown, m_down, m_rem;
  bit model_valid = 1'b0;
  int len_tbl [8] = '{1, 0, 4, 4, 8, 8, 16, 16};

  task automatic model_step();
    int a    = m_aown;
    int nrem = m_rem;
    int ng   = m_gnt;
    if (!rdy) return;
    case (tr[a])
      2'd2: nrem = (len_tbl[bu[a]] > 0) ? len_tbl[bu[a]] - 1 : 0;
      2'd3: if (m_rem > 0) nrem = m_rem - 1;
      2'd0: nrem = 0;
      default: ;
    endcase
    if (!lck[m_gnt] && (nrem == 0 || !breq[m_gnt])) begin
      if (breq[0] && breq[1]) ng = 1 - m_gnt;
      else if (breq[0]) ng = 0;
      else if (breq[1]) ng = 1;
    end
    m_down = m_aown;
    m_aown = m_gnt;
    m_gnt  = ng;
    m_rem  = nrem;
  endtask

  task automatic apply_cycle();
    obs_t e;
    @(negedge HCLK);
    HRESET = rst; HREADY = rdy;
    HBUSREQ0 = breq[0]; HBUSREQ1 = breq[1]; HLOCK0 = lck[0]; HLOCK1 = lck[1];
    HADDR0 = ad[0]; HADDR1 = ad[1]; HWDATA0 = wd[0]; HWDATA1 = wd[1];
    HTRANS0 = tr[0]; HTRANS1 = tr[1]; HWRITE0 = wr[0]; HWRITE1 = wr[1];
    HSIZE0 = sz[0]; HSIZE1 = sz[1]; HBURST0 = bu[0]; HBURST1 = bu[1];
    if (model_valid) begin
      e.g0    = (m_gnt == 0);
      e.g1    = (m_gnt == 1);
      e.mst   = (m_aown == 1);
      e.addr  = ad[m_aown];
      e.trans = tr[m_aown];
      e.wr    = wr[m_aown];
      e.size  = sz[m_aown];
      e.burst = bu[m_aown];
      e.mlock = lck[m_aown];
      e.wdata = wd[m_down];
      exp_q.push_back(e);
    end
    if (rst) begin
      m_gnt = 0; m_aown = 0; m_down = 0; m_rem = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      model_step();
    end
  endtask

  task automatic set_m(input int i, input logic req, input logic lk,
                       input logic [1:0] t, input logic [2:0] b, input logic w);
    breq[i] = req; lck[i] = lk; tr[i] = t; bu[i] = b; wr[i] = w;
    sz[i] = 3'd2; ad[i] = $urandom; wd[i] = $urandom;
  endtask

  // Monitor: compare presented bus outputs against the oldest prediction
  initial begin
    forever begin
      @(negedge HCLK);
      #2;
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = {HGRANT0, HGRANT1, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL bus_outputs t=%0t actual=%h expected=%h", $time, a, e);
        end
      end
    end
  end

  initial begin
    rdy = 1'b1; rst = 1'b1;
    set_m(0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    set_m(1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    repeat (2) apply_cycle();
    rst = 1'b0;

    // Alternation with single transfers from both masters
    for (int i = 0; i < 10; i++) begin
      set_m(0, 1'b1, 1'b0, 2'd2, 3'd0, 1'b1);
      set_m(1, 1'b1, 1'b0, 2'd2, 3'd0, 1'b0);
      apply_cycle();
    end

    // Reset while master 1 holds the grant
    for (int i = 0; i < 3; i++) begin
      set_m(0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
      set_m(1, 1'b1, 1'b1, 2'd2, 3'd0, 1'b0);
      apply_cycle();
    end
    rst = 1'b1; apply_cycle(); rst = 1'b0;
    set_m(1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    apply_cycle();

    // INCR4 from master 0, master 1 competing, wait states mid-burst
    for (int i = 0; i < 12; i++) begin
      set_m(0, i < 6, 1'b0, (i == 0) ? 2'd2 : ((i < 6) ? 2'd3 : 2'd0), 3'd3, 1'b1);
      ad[0] = 32'h1000_0000 + 32'(4 * i);
      set_m(1, i >= 1, 1'b0, 2'd2, 3'd0, 1'b0);
      rdy = !(i == 2 || i == 3);
      apply_cycle();
    end
    rdy = 1'b1;

    // Locked singles from master 1 while master 0 requests
    for (int i = 0; i < 10; i++) begin
      set_m(0, 1'b1, 1'b0, 2'd2, 3'd0, 1'b0);
      set_m(1, i < 6, i < 6, (i < 6) ? 2'd2 : 2'd0, 3'd0, 1'b1);
      apply_cycle();
    end

    // Master 1 transfer then park with no requests
    for (int i = 0; i < 8; i++) begin
      set_m(0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
      set_m(1, i < 2, 1'b0, (i < 2) ? 2'd2 : 2'd0, 3'd0, 1'b1);
      apply_cycle();
    end

    // Long wait state during a write
    for (int i = 0; i < 9; i++) begin
      set_m(0, 1'b1, 1'b0, 2'd2, 3'd0, 1'b1);
      set_m(1, 1'b1, 1'b0, 2'd2, 3'd0, 1'b1);
      rdy = !(i >= 2 && i < 7);
      apply_cycle();
    end
    rdy = 1'b1;

    // Randomized traffic with sticky requests, bursts, locks and resets
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        logic req;
        req = ($urandom_range(0, 3) == 0) ? ~breq[m] : breq[m];
        set_m(m, req, ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) tr[m] = 2'd3;
      end
      rdy = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 99) == 0);
      apply_cycle();
    end
    rst = 1'b0;

    repeat (2) apply_cycle();
    @(negedge HCLK);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
